register_32bits: RTL and testbench

- General-purpose 32-bit edge-triggered storage register with load enable and a true/complement output pair.
- Used as the basic state element of the datapath: any word register, operand latch or pipeline stage.
- Driven by the free-running system clock. Cleared by the global asynchronous active-low reset.

---
 rtl/register_32bits.sv | 40 ++++
 tb/tb_register_32bits.sv | 134 +++++++++++++
 2 files changed

// File: rtl/register_32bits.sv
// 32-bit load-enabled register with a combinational complement output.
// Optional synchronous clear is compiled in when REG_SYNC_CLR_EN is defined.
module register_32bits #(
  parameter int unsigned           WIDTH       = 32,
  parameter logic [WIDTH-1:0]      RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
`ifdef REG_SYNC_CLR_EN
  input  logic             clr,
`endif
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] Q_comp
);

  logic [WIDTH-1:0] q_reg;

`ifdef REG_SYNC_CLR_EN
  // clr outranks enable; the async reset outranks both.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      q_reg <= RESET_VALUE;
    else if (clr)    q_reg <= RESET_VALUE;
    else if (enable) q_reg <= D;
  end
`else
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      q_reg <= RESET_VALUE;
    else if (enable) q_reg <= D;
  end
`endif

  // Complement is derived from the stored word, so it tracks Q even during reset.
  always_comb begin
    Q      = q_reg;
    Q_comp = ~q_reg;
  end

endmodule

// File: tb/tb_register_32bits.sv
// Directed bench for register_32bits: reset, load, hold, latency and async reset.
module tb_register_32bits;

  logic        clk;
  logic        rst_n;
  logic        enable;
  logic [31:0] D;
  logic [31:0] Q;
  logic [31:0] Q_comp;
`ifdef REG_SYNC_CLR_EN
  logic        clr;
`endif

  int unsigned vectors;
  int unsigned miscompares;

  register_32bits #(
    .WIDTH       (32),
    .RESET_VALUE (32'h0000_0000)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .enable (enable),
`ifdef REG_SYNC_CLR_EN
    .clr    (clr),
`endif
    .D      (D),
    .Q      (Q),
    .Q_comp (Q_comp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_pair(input string tag, input logic [31:0] exp_q, input logic [31:0] exp_qc);
    check({tag, " Q"}, Q, exp_q);
    check({tag, " Q_comp"}, Q_comp, exp_qc);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n  = 1'b0;
    enable = 1'b1;
    D      = 32'hFFFF_FFFF;
`ifdef REG_SYNC_CLR_EN
    clr    = 1'b0;
`endif

    // Reset held across two edges with a load pending.
    #1;
    check_pair("reset_initial", 32'h0000_0000, 32'hFFFF_FFFF);
    @(posedge clk); #1;
    check_pair("reset_edge1", 32'h0000_0000, 32'hFFFF_FFFF);
    @(posedge clk); #1;
    check_pair("reset_edge2", 32'h0000_0000, 32'hFFFF_FFFF);

    // Release between edges: nothing loads until the next edge.
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_pair("reset_release", 32'h0000_0000, 32'hFFFF_FFFF);

    // First edge after release loads all-ones.
    @(posedge clk); #1;
    check_pair("load_ones", 32'hFFFF_FFFF, 32'h0000_0000);

    @(negedge clk);
    D = 32'h8000_0801;
    @(posedge clk); #1;
    check_pair("load_pattern", 32'h8000_0801, 32'h7FFF_F7FE);

    // Hold over two edges while D changes.
    @(negedge clk);
    enable = 1'b0;
    D      = 32'hAAAA_AAAA;
    @(posedge clk); #1;
    check_pair("hold_edge1", 32'h8000_0801, 32'h7FFF_F7FE);
    @(negedge clk);
    D = 32'h5555_5555;
    @(posedge clk); #1;
    check_pair("hold_edge2", 32'h8000_0801, 32'h7FFF_F7FE);

    // No transparency while clk is low; one-edge latency.
    @(negedge clk);
    enable = 1'b1;
    D      = 32'h401F_F805;
    #2;
    check_pair("no_transparency", 32'h8000_0801, 32'h7FFF_F7FE);
    @(posedge clk); #1;
    check_pair("latency_load", 32'h401F_F805, 32'hBFE0_07FA);

    // Async reset between edges, with a different load pending.
    D = 32'h1357_9BDF;
    #2;
    rst_n = 1'b0;
    #1;
    check_pair("async_reset", 32'h0000_0000, 32'hFFFF_FFFF);
    @(posedge clk); #1;
    check_pair("reset_wins_edge", 32'h0000_0000, 32'hFFFF_FFFF);

    @(negedge clk);
    rst_n = 1'b1;
    D     = 32'h0F0F_00F0;
    @(posedge clk); #1;
    check_pair("reload_after_reset", 32'h0F0F_00F0, 32'hF0F0_FF0F);

`ifdef REG_SYNC_CLR_EN
    // clr beats enable; with both low the word is held.
    @(negedge clk);
    clr    = 1'b1;
    enable = 1'b1;
    D      = 32'h1234_5678;
    @(posedge clk); #1;
    check_pair("sync_clr", 32'h0000_0000, 32'hFFFF_FFFF);
    @(negedge clk);
    clr = 1'b0;
    @(posedge clk); #1;
    check_pair("after_clr_load", 32'h1234_5678, 32'hEDCB_A987);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
